// File: rtl/gsram_ctrl_if.sv
`default_nettype none
// ============================================================================
// gsram_ctrl_if : request/response channel of the gsram controller (rev 1.0)
// ============================================================================
interface gsram_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_error;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_error, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_error, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/gsram_ctrl.sv
`default_nettype none
// ============================================================================
// gsram_ctrl : clocked master driving the gsram asynchronous SRAM (rev 1.0)
// ============================================================================
module gsram_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_SIZE    = 256,
    parameter int WAIT_CYCLES = 3,
    parameter int TURN_CYCLES = 1
) (
    input  wire                   clk,
    input  wire                   rst,
    gsram_ctrl_if.slave           req,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);
    localparam int c_WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam int c_TURN_W = $clog2(TURN_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LOAD = c_WAIT_W'(WAIT_CYCLES);
    localparam logic [c_TURN_W-1:0]   c_TURN_LOAD = c_TURN_W'(TURN_CYCLES);
    localparam logic [ADDR_WIDTH:0]   c_MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        RECOVER = 3'd4,
        REJECT  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [c_WAIT_W-1:0]   wait_q, wait_d;
    logic [c_TURN_W-1:0]   turn_q, turn_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic                  in_range, strobe;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        turn_d    = turn_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        in_range  = ({1'b0, req.req_addr} < c_MEM_LIMIT);

        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    write_d = req.req_write;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    if (in_range) begin
                        state_d = SETUP;
                    end else begin
                        state_d = REJECT;
                        rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                wait_d  = c_WAIT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                wait_d = wait_q - c_WAIT_W'(1);
                if (wait_q == c_WAIT_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                turn_d  = c_TURN_LOAD;
                state_d = RECOVER;
                if (!write_q) begin
                    rdata_d = mem_data;
                end
            end
            RECOVER: begin
                turn_d = turn_q - c_TURN_W'(1);
                if (turn_q == c_TURN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            REJECT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Memory pins are derived from the next state so they leave a flop cleanly.
        strobe      = (state_d == ACCESS) || (state_d == CAPTURE);
        rd_d        = strobe && !write_d;
        wr_d        = strobe && write_d;
        oe_d        = write_d && ((state_d inside {SETUP, ACCESS, CAPTURE}) || (state_q == CAPTURE));
        rsp_valid_d = (state_q == CAPTURE) || (state_d == REJECT);
        rsp_error_d = (state_d == REJECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            turn_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            turn_q      <= turn_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_error = rsp_error_q;
    assign req.rsp_rdata = rdata_q;

    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_address = addr_q;
    assign mem_data    = oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
endmodule
`default_nettype wire

// File: tb/tb_gsram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gsram_ctrl : directed bench for gsram_ctrl with a wait-state SRAM model (rev 1.0)
// ============================================================================
module tb_gsram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic        valid_a [3];
    logic        write_a [3];
    logic        probe_a [3];
    logic [15:0] addr_a  [3];
    logic [15:0] wdata_a [3];
    logic        rdy_a   [3];
    logic        rv_a    [3];
    logic        err_a   [3];
    logic        rd_a    [3];
    logic        wr_a    [3];
    logic [15:0] rdata_a [3];
    logic [15:0] maddr_a [3];
    logic [15:0] md_a    [3];

    logic        tr_rd [16], tr_wr [16], tr_rv [16], tr_err [16], tr_rdy [16];
    logic [15:0] tr_rdata [16], tr_md [16], tr_maddr [16];
    bit          acc_ok;

    function automatic int wc_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 1 : 8);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int WC = (k == 0) ? 3 : ((k == 1) ? 1 : 8);
        gsram_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
        wire  [15:0] md;
        logic        mrd, mwr;
        logic [15:0] maddr;
        logic [15:0] mem [256];
        int          rdcnt;

        assign bus.req_valid = valid_a[k];
        assign bus.req_write = write_a[k];
        assign bus.req_addr  = addr_a[k];
        assign bus.req_wdata = wdata_a[k];
        assign rdy_a[k]   = bus.req_ready;
        assign rv_a[k]    = bus.rsp_valid;
        assign err_a[k]   = bus.rsp_error;
        assign rdata_a[k] = bus.rsp_rdata;
        assign rd_a[k]    = mrd;
        assign wr_a[k]    = mwr;
        assign maddr_a[k] = maddr;
        assign md_a[k]    = md;

        gsram_ctrl #(
            .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_SIZE(256),
            .WAIT_CYCLES(WC), .TURN_CYCLES(1)
        ) dut (
            .clk(clk), .rst(rst), .req(bus),
            .mem_read(mrd), .mem_write(mwr), .mem_address(maddr), .mem_data(md)
        );

        // Read data only becomes valid after the strobe has been high WC cycles.
        assign md = mrd ? ((rdcnt >= WC) ? mem[maddr[7:0]] : 16'hDEAD)
                        : (probe_a[k] ? 16'h0000 : 16'hzzzz);

        always @(posedge clk) begin
            if (rst) rdcnt <= 0;
            else     rdcnt <= mrd ? rdcnt + 1 : 0;
            if (mwr) mem[maddr[7:0]] <= md;
        end
    end

    task automatic run_txn(input int k, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int ncyc, input int probe_after);
        acc_ok = 1'b0;
        for (int i = 0; i < 100 && !acc_ok; i++) begin
            @(negedge clk);
            if (rdy_a[k]) acc_ok = 1'b1;
        end
        valid_a[k] = 1'b1;
        write_a[k] = wr;
        addr_a[k]  = addr;
        wdata_a[k] = wr ? wdata : 16'hFFFF;
        @(posedge clk);
        #1;
        valid_a[k] = 1'b0;
        write_a[k] = ~wr;
        addr_a[k]  = 16'h0BAD;
        wdata_a[k] = 16'h5A5A;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tr_rd[c] = rd_a[k];   tr_wr[c] = wr_a[k];   tr_rv[c] = rv_a[k];
            tr_err[c] = err_a[k]; tr_rdy[c] = rdy_a[k]; tr_rdata[c] = rdata_a[k];
            tr_md[c] = md_a[k];   tr_maddr[c] = maddr_a[k];
            if (c == probe_after) probe_a[k] = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            valid_a[k] = 1'b0; write_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
            probe_a[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (rdy_a[0] !== 1'b1) $display("FAIL reset_ready: got %b want 1", rdy_a[0]); else passed++;
        checks++; if (rv_a[0] !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rv_a[0]); else passed++;
        checks++; if (err_a[0] !== 1'b0) $display("FAIL reset_rsp_error: got %b want 0", err_a[0]); else passed++;
        checks++; if (rdata_a[0] !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata_a[0]); else passed++;
        checks++; if (rd_a[0] !== 1'b0) $display("FAIL reset_mem_read: got %b want 0", rd_a[0]); else passed++;
        checks++; if (wr_a[0] !== 1'b0) $display("FAIL reset_mem_write: got %b want 0", wr_a[0]); else passed++;
        checks++; if (maddr_a[0] !== 16'h0000) $display("FAIL reset_mem_address: got %h want 0000", maddr_a[0]); else passed++;
        checks++; if (md_a[0] !== 16'h0000) $display("FAIL reset_mem_data_released: got %h want 0000", md_a[0]); else passed++;
        for (int k = 0; k < 3; k++) probe_a[k] = 1'b0;
    endtask

    task automatic test_write();
        logic e_wr, e_rv, e_rdy;
        run_txn(0, 1'b1, 16'h0010, 16'hA5A5, 7, 6);
        checks++; if (!acc_ok) $display("FAIL write_accept: got timeout want ready"); else passed++;
        for (int c = 1; c <= 7; c++) begin
            e_wr = (c >= 2 && c <= 5); e_rv = (c == 6); e_rdy = (c == 7);
            checks++; if (tr_wr[c] !== e_wr) $display("FAIL write_strobe c%0d: got %b want %b", c, tr_wr[c], e_wr); else passed++;
            checks++; if (tr_rd[c] !== 1'b0) $display("FAIL write_no_read c%0d: got %b want 0", c, tr_rd[c]); else passed++;
            checks++; if (tr_rv[c] !== e_rv) $display("FAIL write_rsp_valid c%0d: got %b want %b", c, tr_rv[c], e_rv); else passed++;
            checks++; if (tr_rdy[c] !== e_rdy) $display("FAIL write_ready c%0d: got %b want %b", c, tr_rdy[c], e_rdy); else passed++;
            if (c <= 6) begin
                checks++; if (tr_md[c] !== 16'hA5A5) $display("FAIL write_data_driven c%0d: got %h want a5a5", c, tr_md[c]); else passed++;
                checks++; if (tr_maddr[c] !== 16'h0010) $display("FAIL write_address c%0d: got %h want 0010", c, tr_maddr[c]); else passed++;
            end
        end
        checks++; if (tr_err[6] !== 1'b0) $display("FAIL write_rsp_error: got %b want 0", tr_err[6]); else passed++;
        checks++; if (tr_md[7] !== 16'h0000) $display("FAIL write_data_released: got %h want 0000", tr_md[7]); else passed++;
        probe_a[0] = 1'b0;
    endtask

    task automatic test_read();
        logic e_rd;
        probe_a[0] = 1'b1;
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 7, 0);
        checks++; if (!acc_ok) $display("FAIL read_accept: got timeout want ready"); else passed++;
        for (int c = 1; c <= 7; c++) begin
            e_rd = (c >= 2 && c <= 5);
            checks++; if (tr_rd[c] !== e_rd) $display("FAIL read_strobe c%0d: got %b want %b", c, tr_rd[c], e_rd); else passed++;
            checks++; if (tr_wr[c] !== 1'b0) $display("FAIL read_no_write c%0d: got %b want 0", c, tr_wr[c]); else passed++;
            if (!e_rd) begin
                checks++; if (tr_md[c] !== 16'h0000) $display("FAIL read_bus_released c%0d: got %h want 0000", c, tr_md[c]); else passed++;
            end
        end
        checks++; if (tr_rv[6] !== 1'b1) $display("FAIL read_rsp_valid: got %b want 1", tr_rv[6]); else passed++;
        checks++; if (tr_rdata[6] !== 16'hA5A5) $display("FAIL read_rdata: got %h want a5a5", tr_rdata[6]); else passed++;
        probe_a[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  cnt = 0, rsp_c = 0, both = 0;
        bit  got = 1'b0;
        logic [15:0] rsp_d = 16'h0000;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rdy_a[0]) got = 1'b1;
        end
        valid_a[0] = 1'b1; write_a[0] = 1'b1; addr_a[0] = 16'h00FF; wdata_a[0] = 16'h1234;
        @(posedge clk);
        #1;
        write_a[0] = 1'b0; wdata_a[0] = 16'hFFFF;
        got = 1'b0;
        while (cnt < 20 && !got) begin
            @(negedge clk);
            cnt++;
            if (rd_a[0] && wr_a[0]) both++;
            if (rdy_a[0]) got = 1'b1;
        end
        checks++; if (cnt !== 7) $display("FAIL b2b_accept_spacing: got %0d want 7", cnt); else passed++;
        @(posedge clk);
        #1;
        valid_a[0] = 1'b0; addr_a[0] = 16'h0BAD;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (rd_a[0] && wr_a[0]) both++;
            if (rv_a[0]) begin rsp_c = c; rsp_d = rdata_a[0]; end
        end
        checks++; if (rsp_c !== 6) $display("FAIL b2b_read_rsp_cycle: got %0d want 6", rsp_c); else passed++;
        checks++; if (rsp_d !== 16'h1234) $display("FAIL b2b_read_rdata: got %h want 1234", rsp_d); else passed++;
        checks++; if (both !== 0) $display("FAIL b2b_both_strobes: got %0d want 0", both); else passed++;
    endtask

    task automatic test_reject();
        int strobes = 0;
        run_txn(0, 1'b0, 16'h0100, 16'h0000, 3, 0);
        for (int c = 1; c <= 3; c++) strobes += int'(tr_rd[c]) + int'(tr_wr[c]);
        checks++; if (tr_rv[1] !== 1'b1) $display("FAIL reject_rsp_valid: got %b want 1", tr_rv[1]); else passed++;
        checks++; if (tr_err[1] !== 1'b1) $display("FAIL reject_rsp_error: got %b want 1", tr_err[1]); else passed++;
        checks++; if (tr_rdata[1] !== 16'h0000) $display("FAIL reject_rdata: got %h want 0000", tr_rdata[1]); else passed++;
        checks++; if (tr_rdy[1] !== 1'b0) $display("FAIL reject_ready_c1: got %b want 0", tr_rdy[1]); else passed++;
        checks++; if (tr_rdy[2] !== 1'b1) $display("FAIL reject_ready_c2: got %b want 1", tr_rdy[2]); else passed++;
        checks++; if (tr_rv[2] !== 1'b0) $display("FAIL reject_single_pulse: got %b want 0", tr_rv[2]); else passed++;
        checks++; if (strobes !== 0) $display("FAIL reject_no_strobe: got %0d want 0", strobes); else passed++;
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rdy_a[0]) got = 1'b1;
        end
        valid_a[0] = 1'b1; write_a[0] = 1'b1; addr_a[0] = 16'h0020; wdata_a[0] = 16'h5555;
        @(posedge clk);
        #1;
        valid_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe_a[0] = 1'b1;
        @(negedge clk);
        checks++; if ({rd_a[0], wr_a[0]} !== 2'b00) $display("FAIL rst_mid_strobes: got %b%b want 00", rd_a[0], wr_a[0]); else passed++;
        checks++; if (md_a[0] !== 16'h0000) $display("FAIL rst_mid_data_released: got %h want 0000", md_a[0]); else passed++;
        checks++; if (rv_a[0] !== 1'b0) $display("FAIL rst_mid_rsp_valid: got %b want 0", rv_a[0]); else passed++;
        checks++; if (rdy_a[0] !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", rdy_a[0]); else passed++;
        repeat (6) begin
            @(negedge clk);
            if (rv_a[0]) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL rst_mid_no_response: got %0d want 0", pulses); else passed++;
        run_txn(0, 1'b0, 16'h0020, 16'h0000, 7, 0);
        checks++; if ({tr_rv[6], tr_err[6]} !== 2'b10) $display("FAIL rst_mid_read_rsp: got %b%b want 10", tr_rv[6], tr_err[6]); else passed++;
        checks++; if (tr_rdata[6] !== 16'h5555) $display("FAIL rst_mid_read_rdata: got %h want 5555", tr_rdata[6]); else passed++;
        probe_a[0] = 1'b0;
    endtask

    task automatic test_wait_sweep();
        logic [15:0] a, d;
        int w, hi;
        for (int k = 1; k < 3; k++) begin
            w = wc_of(k);
            for (int n = 0; n < 3; n++) begin
                a = 16'($urandom_range(0, 255));
                d = 16'($urandom);
                run_txn(k, 1'b1, a, d, w + 4, 0);
                checks++; if ({tr_rv[w+3], tr_err[w+3]} !== 2'b10) $display("FAIL sweep_w%0d_write_rsp: got %b%b want 10", w, tr_rv[w+3], tr_err[w+3]); else passed++;
                run_txn(k, 1'b0, a, 16'h0000, w + 4, 0);
                hi = 0;
                for (int c = 1; c <= w + 4; c++) hi += int'(tr_rd[c]);
                checks++; if (hi !== w + 1) $display("FAIL sweep_w%0d_read_strobe_len: got %0d want %0d", w, hi, w + 1); else passed++;
                checks++; if (tr_rv[w+3] !== 1'b1) $display("FAIL sweep_w%0d_read_rsp: got %b want 1", w, tr_rv[w+3]); else passed++;
                checks++; if (tr_rdata[w+3] !== d) $display("FAIL sweep_w%0d_rdata @%h: got %h want %h", w, a, tr_rdata[w+3], d); else passed++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reject();
        test_reset_mid_write();
        test_wait_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gsram_ctrl.md
# gsram_ctrl

Synchronous master for the `gsram` asynchronous SRAM model. It sits directly upstream of the memory: it accepts single-word read/write requests on a valid/ready interface and converts each one into a strobe/address/data sequence on the memory's `read`, `write`, `address` and tri-state `data` pins. It then returns a one-cycle response. It enforces setup, wait-state, hold and bus-turnaround timing in clock cycles, so the asynchronous memory can be used from clocked logic.

## Interface
- `ADDR_WIDTH`, 16: request and memory address width.
- `DATA_WIDTH`, 16: data word width.
- `MEM_SIZE`, 256: number of implemented words. Addresses >= MEM_SIZE are rejected without a memory access.
- `WAIT_CYCLES`, 3: cycles the strobe is held before the capture cycle, >= 1. Must satisfy WAIT_CYCLES × Tclk >= memory wait time + 2 ns.
- `TURN_CYCLES`, 1: idle cycles after each access with both strobes low, >= 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_error`  out  1  qualifies `rsp_valid`; 1 = address out of range.
- `rsp_rdata`  out  DATA_WIDTH  read data; valid with `rsp_valid` for reads.
- `mem_read`  out  1  to memory `read`.
- `mem_write`  out  1  to memory `write`.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_data`  inout  DATA_WIDTH  to memory `data`. Driven only during writes, otherwise high-Z.

## Operation
- States: IDLE, SETUP, ACCESS, CAPTURE, RECOVER, REJECT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch write flag, address and wdata.
  - Address < MEM_SIZE → SETUP; otherwise → REJECT.
- SETUP (1 cycle):
  - `mem_address` = latched address.
  - Strobes low.
  - For writes, `mem_data` driven with latched wdata.
- ACCESS (WAIT_CYCLES cycles, counted by a down-counter of width $clog2(WAIT_CYCLES+1)):
  - Exactly one strobe is high: `mem_write` for a write, `mem_read` for a read.
  - Address and write data are stable.
- CAPTURE (1 cycle):
  - Strobe still high.
  - For reads, `mem_data` is registered into `rsp_rdata` at the closing edge.
- RECOVER (TURN_CYCLES cycles):
  - Both strobes low.
  - Address held.
  - Write data is driven for the first RECOVER cycle only (hold time), then released to high-Z.
  - `rsp_valid`=1 in the first RECOVER cycle, with `rsp_error`=0.
  - → IDLE after the last cycle.
- REJECT (1 cycle):
  - No strobe.
  - `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0.
  - → IDLE.
- Invariants:
  - `mem_read` & `mem_write` never both 1.
  - Strobes are never high outside ACCESS/CAPTURE.
  - `mem_data` is never driven while `mem_read`=1.
- Write responses leave `rsp_rdata` unchanged.
- No response backpressure; the consumer must take `rsp_valid` when it pulses.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0.
  - `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_data`=Z.
- All memory-side outputs are registered (glitch-free strobes).
- Accept edge = cycle 0. Then:
  - SETUP is cycle 1.
  - Strobe is high in cycles 2 .. 2+WAIT_CYCLES.
  - `rsp_valid` is in cycle 3+WAIT_CYCLES.
  - `req_ready` returns in cycle 3+WAIT_CYCLES+TURN_CYCLES.
- Throughput: one access per 3+WAIT_CYCLES+TURN_CYCLES cycles.
- Out-of-range request: `rsp_valid` in cycle 1, `req_ready` again in cycle 2.
- `req_*` inputs are ignored while `req_ready`=0. Request data is sampled only at the accept edge.
- Reset mid-operation: at the reset edge, strobes drop, `mem_data` goes high-Z, and no response is issued for the aborted request.

## Test plan
- Reset, then write 0xA5A5 @0x0010 with WAIT_CYCLES=3 and TURN_CYCLES=1.
  - `mem_write` high for exactly 4 cycles (cycles 2-5).
  - `rsp_valid` in cycle 6 with `rsp_error`=0.
  - `req_ready` back in cycle 7.
- Read @0x0010 after that write.
  - `rsp_rdata`=0xA5A5 in the response cycle.
  - `mem_data` is never driven by the controller during the read.
- Back-to-back requests with `req_valid` held high: write 0x1234 @0x00FF, then read @0x00FF.
  - Second accept occurs exactly 7 cycles after the first.
  - Read returns 0x1234.
  - Never both strobes high at once.
- Read @0x0100 with MEM_SIZE=256.
  - `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0 in cycle 1.
  - No strobe ever asserted.
- Assert `rst` in cycle 3 of a write.
  - Next cycle: strobes=0, `mem_data`=Z, `rsp_valid`=0, `req_ready`=1.
  - A subsequent read of that address completes normally.
- Sweep WAIT_CYCLES=1 and 8 with the memory wait time scaled accordingly: random write/read pairs return the written data.
